// File: rtl/de_pkg.sv
// Shared definitions for the decode-to-execute issue stage.
// Optional forwarding datapath is selected with the DE_BYPASS_EN macro.
package de_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Forwarding source indices: lower index is younger and wins on a tie.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  // A forwarding source matches when it holds a live writer of the same
  // non-zero register.
  function automatic logic fwd_hit(input logic valid, input logic wen,
                                   input logic [REG_AW-1:0] waddr,
                                   input logic [REG_AW-1:0] raddr);
    return valid & wen & (waddr == raddr) & (raddr != REG_ZERO);
  endfunction

endpackage

// File: rtl/de_issue_stage_fwd_select.sv
// Per-operand forwarding selector: priority-encodes the matching
// forwarding sources (youngest wins) and resolves the operand and hazard.
// DE_BYPASS_EN defined: forwarded data is used, hazard only if the winning
// source is not ready. Undefined: operand always comes from the register
// file and any match on a used operand is a hazard.
module fwd_select
  import de_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic [REG_AW-1:0]      raddr,
  input  logic                   rused,
  input  logic [XLEN-1:0]        rf_data,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_wen,
  input  logic [NFWD*REG_AW-1:0] fwd_waddr,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]        opnd,
  output logic                   hazard
);

  localparam int IDXW = (NFWD > 1) ? $clog2(NFWD) : 1;

  logic [NFWD-1:0] match;
  logic            hit;
  logic [IDXW-1:0] win;
  logic [XLEN-1:0] sel_data;
  logic            sel_rdy;

  // Raw address match against every forwarding source.
  always_comb begin
    match = '0;
    for (int j = 0; j < NFWD; j++) begin
      match[j] = fwd_hit(fwd_valid[j], fwd_wen[j],
                         fwd_waddr[j*REG_AW +: REG_AW], raddr);
    end
  end

  // Priority encoder: scan oldest to youngest so the youngest match is last.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int j = NFWD - 1; j >= FWD_EX; j--) begin
      if (match[j]) begin
        hit = 1'b1;
        win = IDXW'(j);
      end
    end
  end

  // Winner data/ready mux.
  always_comb begin
    sel_data = '0;
    sel_rdy  = 1'b0;
    for (int j = 0; j < NFWD; j++) begin
      if (win == IDXW'(j)) begin
        sel_data = fwd_data[j*XLEN +: XLEN];
        sel_rdy  = fwd_rdy[j];
      end
    end
  end

`ifdef DE_BYPASS_EN
  // Operand resolution with full forwarding; r0 always reads as zero.
  always_comb begin
    opnd   = rf_data;
    hazard = rused & hit & ~sel_rdy;
    if (raddr == REG_ZERO) begin
      opnd = '0;
    end else if (hit) begin
      opnd = sel_data;
    end
  end
`else
  // No bypass: wait until the writer has left the pipe; the write-before-read
  // register file then supplies the value.
  always_comb begin
    opnd   = (raddr == REG_ZERO) ? '0 : rf_data;
    hazard = rused & hit;
  end

  logic unused_fwd;
  assign unused_fwd = ^{sel_data, sel_rdy};
`endif

endmodule

// File: rtl/de_issue_stage.sv
// Decode-to-execute issue stage: operand forwarding, hazard stall,
// valid/ready output register with flush, saturating stall counter.
// Optional full forwarding is enabled by defining DE_BYPASS_EN.
module de_issue_stage
  import de_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 3,
  parameter int CW   = 64,
  parameter int CNTW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*5-1:0]      in_raddr,
  input  logic [NSRC-1:0]        in_rused,
  input  logic [NSRC*XLEN-1:0]   in_rf_data,
  input  logic [4:0]             in_waddr,
  input  logic                   in_wen,
  input  logic [CW-1:0]          in_ctrl,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_wen,
  input  logic [NFWD*5-1:0]      fwd_waddr,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          out_ctrl,
  output logic [NSRC*XLEN-1:0]   out_opnd,
  output logic [4:0]             out_waddr,
  output logic                   out_wen,
  output logic [CNTW-1:0]        stall_cnt
);

  logic [NSRC*XLEN-1:0] opnd_res;
  logic [NSRC-1:0]      haz_vec;
  logic                 hazard;
  logic                 fire;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_select #(
      .XLEN (XLEN),
      .NFWD (NFWD)
    ) u_fwd_select (
      .raddr     (in_raddr[i*REG_AW +: REG_AW]),
      .rused     (in_rused[i]),
      .rf_data   (in_rf_data[i*XLEN +: XLEN]),
      .fwd_valid (fwd_valid),
      .fwd_wen   (fwd_wen),
      .fwd_waddr (fwd_waddr),
      .fwd_rdy   (fwd_rdy),
      .fwd_data  (fwd_data),
      .opnd      (opnd_res[i*XLEN +: XLEN]),
      .hazard    (haz_vec[i])
    );
  end

  // Handshake: a transfer happens on a side when valid & ready are both high
  // at the clock edge. in_ready never depends on in_valid; once out_valid is
  // raised, the payload stays bit-stable until out_ready is seen high.
  assign hazard   = |haz_vec;
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign fire     = in_valid & in_ready;

  // Output register: flush kills, fire loads, acceptance without fire bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_opnd  <= '0;
      out_waddr <= '0;
      out_wen   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_opnd  <= opnd_res;
      out_waddr <= in_waddr;
      out_wen   <= in_wen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles a presented instruction is held by a hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid & hazard & ~flush & (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_de_issue_stage.sv
// Bench for de_issue_stage: table of operand-resolution vectors plus
// hand-written hold, flush, write-back-stall and reset sequences.
module tb_de_issue_stage;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int NFWD = 3;
  localparam int CW   = 64;
  localparam int CNTW = 32;
  localparam int PW   = CW + NSRC*XLEN + 5 + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [NSRC*5-1:0]    in_raddr;
  logic [NSRC-1:0]      in_rused;
  logic [NSRC*XLEN-1:0] in_rf_data;
  logic [4:0]           in_waddr;
  logic                 in_wen;
  logic [CW-1:0]        in_ctrl;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_wen;
  logic [NFWD*5-1:0]    fwd_waddr;
  logic [NFWD-1:0]      fwd_rdy;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_ctrl;
  logic [NSRC*XLEN-1:0] out_opnd;
  logic [4:0]           out_waddr;
  logic                 out_wen;
  logic [CNTW-1:0]      stall_cnt;

  de_issue_stage #(
    .XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .CW(CW), .CNTW(CNTW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_raddr   (in_raddr),
    .in_rused   (in_rused),
    .in_rf_data (in_rf_data),
    .in_waddr   (in_waddr),
    .in_wen     (in_wen),
    .in_ctrl    (in_ctrl),
    .fwd_valid  (fwd_valid),
    .fwd_wen    (fwd_wen),
    .fwd_waddr  (fwd_waddr),
    .fwd_rdy    (fwd_rdy),
    .fwd_data   (fwd_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_opnd   (out_opnd),
    .out_waddr  (out_waddr),
    .out_wen    (out_wen),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic [4:0]  ra0, ra1;
    logic [1:0]  ru;
    logic [31:0] r0, r1;
    logic [2:0]  fv, fw, fr;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [31:0] e0, e1;   // expected operands with forwarding
    logic        eh;       // expected hazard with forwarding
    logic        nh;       // expected hazard without forwarding
  } vec_t;

  typedef struct packed {
    logic [CW-1:0]        ctrl;
    logic [NSRC*XLEN-1:0] opnd;
    logic [4:0]           waddr;
    logic                 wen;
  } pay_t;

  vec_t       vecs[$];
  logic [PW-1:0] exp_q[$];
  pay_t       held;
  logic       m_valid;
  logic [CNTW-1:0] exp_stall;
  int         n_chk  = 0;
  int         n_pass = 0;

  function automatic vec_t mk(string nm, logic [4:0] ra0, logic [4:0] ra1,
                              logic [1:0] ru, logic [31:0] r0, logic [31:0] r1,
                              logic [2:0] fv, logic [2:0] fw, logic [2:0] fr,
                              logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] e0, logic [31:0] e1,
                              logic eh, logic nh);
    vec_t v;
    v.name = nm; v.ra0 = ra0; v.ra1 = ra1; v.ru = ru; v.r0 = r0; v.r1 = r1;
    v.fv = fv; v.fw = fw; v.fr = fr; v.fa = {a2, a1, a0};
    v.fd = {32'h33, 32'h22, 32'h11};
    v.e0 = e0; v.e1 = e1; v.eh = eh; v.nh = nh;
    return v;
  endfunction

  // ---------------- scoreboard / checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_ctrl"},  128'(out_ctrl),  128'(0));
    chk({tag, "_out_opnd"},  128'(out_opnd),  128'(0));
    chk({tag, "_out_waddr"}, 128'(out_waddr), 128'(0));
    chk({tag, "_out_wen"},   128'(out_wen),   128'(0));
    chk({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    repeat (ncyc - 1) @(posedge clk);
    m_valid = 1'b0;
    exp_stall = '0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Apply one vector for one cycle with the given in_valid/out_ready/flush.
  task automatic apply(input vec_t v, input logic iv, input logic ordy, input logic fl);
    logic        haz, rdy, fire;
    logic [31:0] e0, e1;
    pay_t        p;
    pay_t        got;
    @(negedge clk);
    in_valid   = iv;
    out_ready  = ordy;
    flush      = fl;
    in_raddr   = {v.ra1, v.ra0};
    in_rused   = v.ru;
    in_rf_data = {v.r1, v.r0};
    fwd_valid  = v.fv;
    fwd_wen    = v.fw;
    fwd_rdy    = v.fr;
    fwd_waddr  = v.fa;
    fwd_data   = v.fd;
    in_ctrl    = {$urandom(), $urandom()};
    in_waddr   = 5'($urandom_range(0, 31));
    in_wen     = 1'($urandom_range(0, 1));
`ifdef DE_BYPASS_EN
    haz = v.eh;
    e0  = v.e0;
    e1  = v.e1;
`else
    haz = v.nh;
    e0  = (v.ra0 == 5'd0) ? 32'd0 : v.r0;
    e1  = (v.ra1 == 5'd0) ? 32'd0 : v.r1;
`endif
    rdy  = ~fl & ~haz & (~m_valid | ordy);
    fire = iv & rdy;
    if (iv & haz & ~fl & (exp_stall != {CNTW{1'b1}})) exp_stall++;
    if (fire) begin
      p.ctrl = in_ctrl; p.opnd = {e1, e0}; p.waddr = in_waddr; p.wen = in_wen;
      exp_q.push_back(p);
    end
    #2;
    chk({v.name, "_in_ready"}, 128'(in_ready), 128'(rdy));
    @(posedge clk); #1;
    if (fl) m_valid = 1'b0;
    else if (fire) begin
      m_valid = 1'b1;
      held = exp_q.pop_front();
    end else if (ordy) m_valid = 1'b0;
    chk({v.name, "_out_valid"}, 128'(out_valid), 128'(m_valid));
    if (m_valid) begin
      got.ctrl = out_ctrl; got.opnd = out_opnd; got.waddr = out_waddr; got.wen = out_wen;
      chk({v.name, "_out_opnd"}, 128'(got.opnd), 128'(held.opnd));
      chk({v.name, "_out_ctrl_waddr_wen"}, 128'({got.ctrl, got.waddr, got.wen}),
          128'({held.ctrl, held.waddr, held.wen}));
    end
    chk({v.name, "_stall_cnt"}, 128'(stall_cnt), 128'(exp_stall));
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t        v;
    logic [31:0] ra, rb;
    logic [CNTW-1:0] s_before;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_raddr = '0; in_rused = '0; in_rf_data = '0; in_waddr = '0; in_wen = 1'b0;
    in_ctrl = '0; fwd_valid = '0; fwd_wen = '0; fwd_waddr = '0; fwd_rdy = '0;
    fwd_data = '0; m_valid = 1'b0; exp_stall = '0; held = '0;

    ra = $urandom(); rb = $urandom();
    //                name              ra0 ra1 ru     r0  r1  fv      fw      fr      a0 a1 a2 e0           e1            eh nh
    vecs.push_back(mk("no_match",        2,  3, 2'b11, ra, rb, 3'b000, 3'b000, 3'b111, 0, 0, 0, ra,          rb,           0, 0));
    vecs.push_back(mk("ex_wb_r5",        5,  1, 2'b11, ra, rb, 3'b101, 3'b101, 3'b111, 5, 0, 5, 32'h11,      rb,           0, 1));
    vecs.push_back(mk("wb_r5",           5,  1, 2'b11, ra, rb, 3'b100, 3'b100, 3'b111, 5, 0, 5, 32'h33,      rb,           0, 1));
    v = mk("r0_forward",                 0,  1, 2'b11, ra, rb, 3'b001, 3'b001, 3'b000, 0, 0, 0, 32'h0,       rb,           0, 0);
    v.fd[31:0] = 32'hFFFF_FFFF;
    vecs.push_back(v);
    vecs.push_back(mk("unused_pending",  2,  8, 2'b01, ra, rb, 3'b001, 3'b001, 3'b000, 8, 0, 0, ra,          32'h11,       0, 0));
    vecs.push_back(mk("used_pending",    2,  8, 2'b11, ra, rb, 3'b001, 3'b001, 3'b000, 8, 0, 0, ra,          32'h11,       1, 1));
    v = mk("mem_ready_r8",               2,  8, 2'b11, ra, rb, 3'b010, 3'b010, 3'b111, 0, 8, 0, ra,          32'hABCD,     0, 1);
    v.fd[63:32] = 32'hABCD;
    vecs.push_back(v);
    vecs.push_back(mk("two_ops",         3,  4, 2'b11, ra, rb, 3'b110, 3'b110, 3'b111, 0, 3, 4, 32'h22,      32'h33,       0, 1));
    vecs.push_back(mk("young_not_rdy",   6,  1, 2'b11, ra, rb, 3'b101, 3'b101, 3'b100, 6, 0, 6, 32'h11,      rb,           1, 1));
    vecs.push_back(mk("fwd_not_valid",   9,  1, 2'b11, ra, rb, 3'b000, 3'b111, 3'b000, 9, 9, 9, ra,          rb,           0, 0));
    vecs.push_back(mk("fwd_no_wen",      9,  1, 2'b11, ra, rb, 3'b111, 3'b000, 3'b000, 9, 9, 9, ra,          rb,           0, 0));
    vecs.push_back(mk("rf_only",        31,  0, 2'b11, ra, rb, 3'b000, 3'b000, 3'b000, 0, 0, 0, ra,          32'h0,        0, 0));

    do_reset(2);

    // Table: every vector with EX always ready.
    foreach (vecs[k]) apply(vecs[k], 1'b1, 1'b1, 1'b0);

    // Hold: three cycles of backpressure, then a new issue once accepted.
    apply(vecs[0], 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) apply(vecs[2], 1'b1, 1'b0, 1'b0);
    apply(vecs[11], 1'b1, 1'b1, 1'b0);
    apply(vecs[0], 1'b0, 1'b1, 1'b0);

    // Flush while held, then flush colliding with a would-be fire.
    apply(vecs[0], 1'b1, 1'b1, 1'b0);
    apply(vecs[0], 1'b1, 1'b0, 1'b1);
    apply(vecs[11], 1'b1, 1'b1, 1'b0);
    apply(vecs[0], 1'b0, 1'b1, 1'b0);
    apply(vecs[0], 1'b1, 1'b1, 1'b1);
    apply(vecs[11], 1'b1, 1'b1, 1'b0);

    // Write-back-only match: forwarded directly, or exactly one stall cycle.
    apply(vecs[0], 1'b0, 1'b1, 1'b0);
    s_before = stall_cnt;
    v = mk("wb_only",       7, 1, 2'b11, ra, rb, 3'b100, 3'b100, 3'b100, 0, 0, 7, 32'h33, rb, 0, 1);
    apply(v, 1'b1, 1'b1, 1'b0);
    v = mk("wb_retired",    7, 1, 2'b11, ra, rb, 3'b000, 3'b100, 3'b100, 0, 0, 7, ra,     rb, 0, 0);
`ifdef DE_BYPASS_EN
    apply(vecs[0], 1'b0, 1'b1, 1'b0);
    chk("wb_only_stall_delta", 128'(stall_cnt - s_before), 128'(0));
`else
    apply(v, 1'b1, 1'b1, 1'b0);
    chk("wb_only_stall_delta", 128'(stall_cnt - s_before), 128'(1));
`endif

    // Reset in the middle of a hold with a stalled instruction.
    apply(vecs[0], 1'b1, 1'b1, 1'b0);
    apply(vecs[5], 1'b1, 1'b0, 1'b0);
    do_reset(1);
    apply(vecs[0], 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
